// File: rtl/eth_tx_frame_arbiter.sv
// eth_tx_frame_arbiter: frame-atomic N:1 AXI-Stream merger feeding the GMII MAC
// transmitter. Arbitration is round-robin or strict priority, gated by a
// per-channel enable mask. Frames longer than MAX_FRAME_LEN are cut short and
// flagged bad. A programmable inter-frame gap follows every frame, and each
// channel has toggle-style status outputs for crossing into the logic domain.
module eth_tx_frame_arbiter #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ARB_MODE      = 0,
  parameter int unsigned MAX_FRAME_LEN = 1522,
  localparam int unsigned CW           = $clog2(CHANNELS)
) (
  input  logic                           tx_clk,
  input  logic                           tx_rst,
  input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [CHANNELS-1:0]            s_axis_tvalid,
  output logic [CHANNELS-1:0]            s_axis_tready,
  input  logic [CHANNELS-1:0]            s_axis_tlast,
  input  logic [CHANNELS-1:0]            s_axis_tuser,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tuser,
  input  logic [CHANNELS-1:0]            chan_enable,
  input  logic [7:0]                     gap_cycles,
  output logic [CW-1:0]                  grant,
  output logic                           busy,
  output logic [CHANNELS-1:0]            stat_frame_toggle,
  output logic [CHANNELS-1:0]            stat_trunc_toggle
);

  localparam int unsigned LW = $clog2(MAX_FRAME_LEN + 1);
  localparam int unsigned IW = CW + 1;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, GAP} state_t;

  state_t                state_q;
  logic [CW-1:0]         grant_q;
  logic [CW-1:0]         rr_q;
  logic [LW-1:0]         cnt_q;
  logic [7:0]            gap_q;
  logic [CHANNELS-1:0]   ftog_q;
  logic [CHANNELS-1:0]   ttog_q;

  logic [CHANNELS-1:0]   req_c;
  logic [CW-1:0]         sel_c;
  logic                  found_c;
  logic [IW-1:0]         idx_c;
  logic [DATA_WIDTH-1:0] g_data_c;
  logic                  g_valid_c;
  logic                  g_last_c;
  logic                  g_user_c;
  logic                  trunc_c;
  logic                  m_hs_c;
  logic                  d_end_c;
  logic [CW-1:0]         next_ptr_c;
  state_t                post_frame_c;

  // Channel selection: lowest index, or first request at/after the RR pointer
  always_comb begin
    req_c   = s_axis_tvalid & chan_enable;
    sel_c   = '0;
    found_c = 1'b0;
    idx_c   = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (ARB_MODE == 1) begin
        idx_c = IW'(k);
      end else begin
        idx_c = {1'b0, rr_q} + IW'(k);
        if (idx_c >= IW'(CHANNELS)) idx_c = idx_c - IW'(CHANNELS);
      end
      if (!found_c && req_c[idx_c[CW-1:0]]) begin
        found_c = 1'b1;
        sel_c   = idx_c[CW-1:0];
      end
    end
  end

  // Mux the granted channel's sideband and derive frame-end events
  always_comb begin
    g_data_c  = '0;
    g_valid_c = 1'b0;
    g_last_c  = 1'b0;
    g_user_c  = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (grant_q == CW'(i)) begin
        g_data_c  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        g_valid_c = s_axis_tvalid[i];
        g_last_c  = s_axis_tlast[i];
        g_user_c  = s_axis_tuser[i];
      end
    end
    trunc_c      = (cnt_q == LW'(MAX_FRAME_LEN - 1)) && !g_last_c;
    m_hs_c       = (state_q == XFER) && g_valid_c && m_axis_tready;
    d_end_c      = (state_q == DRAIN) && g_valid_c && g_last_c;
    next_ptr_c   = (grant_q == CW'(CHANNELS - 1)) ? '0 : grant_q + CW'(1);
    post_frame_c = (gap_cycles != 8'd0) ? GAP : IDLE;
  end

  // Stream pass-through in XFER, sink-only in DRAIN, everything quiet otherwise
  always_comb begin
    s_axis_tready = '0;
    m_axis_tdata  = g_data_c;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    case (state_q)
      XFER: begin
        m_axis_tvalid          = g_valid_c;
        m_axis_tlast           = g_last_c | trunc_c;
        m_axis_tuser           = g_user_c | trunc_c;
        s_axis_tready[grant_q] = m_axis_tready;
      end
      DRAIN:   s_axis_tready[grant_q] = 1'b1;
      default: ;
    endcase
  end

  // Arbitration FSM with beat counter, gap counter and status toggles
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      ftog_q  <= '0;
      ttog_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found_c) begin
            grant_q <= sel_c;
            cnt_q   <= '0;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (m_hs_c) begin
            cnt_q <= cnt_q + LW'(1);
            if (g_last_c || trunc_c) begin
              ftog_q[grant_q] <= ~ftog_q[grant_q];
              rr_q            <= next_ptr_c;
              if (g_last_c) begin
                gap_q   <= gap_cycles;
                state_q <= post_frame_c;
              end else begin
                ttog_q[grant_q] <= ~ttog_q[grant_q];
                state_q         <= DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          if (d_end_c) begin
            gap_q   <= gap_cycles;
            state_q <= post_frame_c;
          end
        end
        GAP: begin
          gap_q <= gap_q - 8'd1;
          if (gap_q == 8'd1) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant             = grant_q;
  assign busy              = (state_q != IDLE);
  assign stat_frame_toggle = ftog_q;
  assign stat_trunc_toggle = ttog_q;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Bench for eth_tx_frame_arbiter: queue-fed sources, scoreboard monitor,
// directed frame scenarios on a round-robin instance (MAX_FRAME_LEN=8) and
// a strict-priority instance.
module tb_eth_tx_frame_arbiter;

  localparam int NCH  = 4;
  localparam int DW   = 8;
  localparam int MAXL = 8;

  logic tx_clk = 1'b0;
  logic tx_rst;
  always #5 tx_clk = ~tx_clk;

  // round-robin instance
  logic [NCH*DW-1:0] s_tdata;
  logic [NCH-1:0]    s_tvalid, s_tready, s_tlast, s_tuser;
  logic [DW-1:0]     m_tdata;
  logic              m_tvalid, m_tready, m_tlast, m_tuser;
  logic [NCH-1:0]    chan_en;
  logic [7:0]        gap_cyc;
  logic [1:0]        grant;
  logic              busy;
  logic [NCH-1:0]    ftog, ttog;

  // strict-priority instance
  logic [NCH*DW-1:0] sp_tdata;
  logic [NCH-1:0]    sp_tvalid, sp_tready, sp_tlast, sp_tuser, sp_en;
  logic [DW-1:0]     sp_m_tdata;
  logic              sp_m_tvalid, sp_m_tready, sp_m_tlast, sp_m_tuser;
  logic [7:0]        sp_gap;
  logic [1:0]        sp_grant;
  logic              sp_busy;
  logic [NCH-1:0]    sp_ftog, sp_ttog;

  eth_tx_frame_arbiter #(.CHANNELS(NCH), .DATA_WIDTH(DW), .ARB_MODE(0), .MAX_FRAME_LEN(MAXL)) u_dut (
    .tx_clk(tx_clk), .tx_rst(tx_rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .chan_enable(chan_en), .gap_cycles(gap_cyc), .grant(grant), .busy(busy),
    .stat_frame_toggle(ftog), .stat_trunc_toggle(ttog)
  );

  eth_tx_frame_arbiter #(.CHANNELS(NCH), .DATA_WIDTH(DW), .ARB_MODE(1)) u_sp (
    .tx_clk(tx_clk), .tx_rst(tx_rst),
    .s_axis_tdata(sp_tdata), .s_axis_tvalid(sp_tvalid), .s_axis_tready(sp_tready),
    .s_axis_tlast(sp_tlast), .s_axis_tuser(sp_tuser),
    .m_axis_tdata(sp_m_tdata), .m_axis_tvalid(sp_m_tvalid), .m_axis_tready(sp_m_tready),
    .m_axis_tlast(sp_m_tlast), .m_axis_tuser(sp_m_tuser),
    .chan_enable(sp_en), .gap_cycles(sp_gap), .grant(sp_grant), .busy(sp_busy),
    .stat_frame_toggle(sp_ftog), .stat_trunc_toggle(sp_ttog)
  );

  logic [9:0]     srcq [NCH][$];   // {user, last, data} per source beat
  logic [11:0]    expq [$];        // {chan, user, last, data} per output beat
  logic [9:0]     spq  [$];        // {chan, data} for the priority instance
  logic [NCH-1:0] pend;
  logic [NCH-1:0] exp_ftog, exp_ttog;
  bit             rnd_en;
  int             total, bad, nbeats, sp_cnt, seq;
  bit             meas_run, meas_done;
  int             cb, ci, meas_busy, meas_idle;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Queue one source frame and the output beats it must produce
  task automatic send(input int ch, input int len, input bit usr);
    logic [7:0] d;
    logic       lst, u;
    for (int k = 0; k < len; k++) begin
      d   = {ch[1:0], seq[5:0]};
      seq++;
      lst = (k == len - 1);
      u   = lst & usr;
      srcq[ch].push_back({u, lst, d});
      if (k < MAXL) begin
        if (k == MAXL - 1 && !lst) expq.push_back({ch[1:0], 1'b1, 1'b1, d});
        else                       expq.push_back({ch[1:0], u, lst, d});
      end
    end
    exp_ftog[ch] = ~exp_ftog[ch];
    if (len > MAXL) exp_ttog[ch] = ~exp_ttog[ch];
  endtask

  task automatic wait_done(input string name, input int maxc);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge tx_clk); #3;
      if (expq.size() == 0 && srcq[0].size() == 0 && srcq[1].size() == 0 &&
          srcq[2].size() == 0 && srcq[3].size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_completes"}, 32'(ok), 32'd1);
  endtask

  // Source model: present queue heads, retire beats that handshook
  task automatic driver_loop();
    forever begin
      @(negedge tx_clk);
      if (tx_rst) pend = '0;
      for (int i = 0; i < NCH; i++)
        if (pend[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
      for (int i = 0; i < NCH; i++) begin
        if (srcq[i].size() > 0 && !(rnd_en && $urandom_range(0, 3) == 0)) begin
          s_tvalid[i] = 1'b1;
          {s_tuser[i], s_tlast[i], s_tdata[i*DW +: DW]} = srcq[i][0];
        end else begin
          s_tvalid[i] = 1'b0;
          s_tlast[i]  = 1'b0;
          s_tuser[i]  = 1'b0;
          s_tdata[i*DW +: DW] = '0;
        end
      end
      m_tready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      pend = s_tvalid & s_tready;
    end
  endtask

  // Monitor: score every output handshake and measure the post-frame quiet time
  task automatic monitor_loop();
    logic [11:0] e;
    logic [9:0]  se;
    forever begin
      @(negedge tx_clk); #2;
      if (!tx_rst) begin
        if (meas_run) begin
          if (m_tvalid) begin
            meas_busy = cb; meas_idle = ci; meas_run = 1'b0; meas_done = 1'b1;
          end else if (busy) cb++;
          else ci++;
        end
        if (m_tvalid && m_tready) begin
          nbeats++;
          if (expq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_beat: got data=0x%0h last=%0b, wanted no beat", m_tdata, m_tlast);
          end else begin
            e = expq.pop_front();
            chk("beat_data",  32'(m_tdata), 32'(e[7:0]));
            chk("beat_last",  32'(m_tlast), 32'(e[8]));
            chk("beat_user",  32'(m_tuser), 32'(e[9]));
            chk("beat_grant", 32'(grant),   32'(e[11:10]));
          end
          if (m_tlast) begin meas_run = 1'b1; cb = 0; ci = 0; end
        end
        if (sp_m_tvalid) begin
          sp_cnt++;
          if (spq.size() == 0) begin
            total++; bad++;
            $display("FAIL sp_unexpected_beat: got chan=%0d, wanted no beat", sp_grant);
          end else begin
            se = spq.pop_front();
            chk("sp_grant", 32'(sp_grant),   32'(se[9:8]));
            chk("sp_data",  32'(sp_m_tdata), 32'(se[7:0]));
            chk("sp_last",  32'(sp_m_tlast), 32'd1);
            chk("sp_user",  32'(sp_m_tuser), 32'd0);
            chk("sp_ready", 32'(sp_tready),  32'(4'b0001 << se[9:8]));
          end
        end
      end
    end
  endtask

  initial begin
    int n0;
    int gaps [2];
    tx_rst = 1'b1; chan_en = '1; gap_cyc = '0; rnd_en = 1'b0; pend = '0;
    s_tdata = '0; s_tvalid = '0; s_tlast = '0; s_tuser = '0; m_tready = 1'b1;
    sp_tdata = {8'd3, 8'd2, 8'd1, 8'd0}; sp_tvalid = '0; sp_tlast = '1; sp_tuser = '0;
    sp_en = '1; sp_gap = '0; sp_m_tready = 1'b1;
    exp_ftog = '0; exp_ttog = '0; total = 0; bad = 0; nbeats = 0; sp_cnt = 0; seq = 0;
    meas_run = 1'b0; meas_done = 1'b0; cb = 0; ci = 0; meas_busy = 0; meas_idle = 0;
    gaps[0] = 5; gaps[1] = 1;
    fork
      driver_loop();
      monitor_loop();
    join_none

    repeat (3) @(negedge tx_clk);
    #3;
    chk("rst_grant",  32'(grant),    32'd0);
    chk("rst_busy",   32'(busy),     32'd0);
    chk("rst_sready", 32'(s_tready), 32'd0);
    chk("rst_mvalid", 32'(m_tvalid), 32'd0);
    chk("rst_ftog",   32'(ftog),     32'd0);
    chk("rst_ttog",   32'(ttog),     32'd0);
    tx_rst = 1'b0;

    // round-robin over all four channels, then wrap back to ch0
    send(0, 3, 0); send(1, 3, 0); send(2, 3, 0); send(3, 3, 0); send(0, 3, 0);
    for (int c = 0; c < 200; c++) begin
      @(negedge tx_clk); #3;
      if (nbeats >= 12) break;
    end
    @(posedge tx_clk); #1;
    chk("rr_ftog_after4", 32'(ftog), 32'h0000000F);
    meas_done = 1'b0;
    wait_done("rr", 200);
    chk("rr_gap_seen", 32'(meas_done), 32'd1);
    chk("rr_gap_busy", 32'(meas_busy), 32'd0);
    chk("rr_gap_idle", 32'(meas_idle), 32'd1);
    chk("rr_ftog", 32'(ftog), 32'(exp_ftog));

    // masked ch1 waits; ch2 goes first although the pointer sits at ch1
    chan_en = 4'b1101;
    send(2, 3, 0); send(1, 3, 0);
    repeat (10) @(negedge tx_clk);
    #3;
    chk("mask_ch1_held", srcq[1].size(), 32'd3);
    chk("mask_idle", 32'(busy), 32'd0);
    chan_en = '1;
    wait_done("mask", 200);

    // pointer now at ch2: ch0 and ch1 pending -> ch0 first via wrap
    send(0, 2, 0); send(1, 2, 0);
    wait_done("rr_wrap", 200);
    chk("wrap_ftog", 32'(ftog), 32'(exp_ftog));

    // truncation of a 12-beat frame, then an exact MAXL-beat frame
    send(2, 12, 0); send(2, MAXL, 0);
    meas_done = 1'b0;
    wait_done("trunc", 300);
    chk("trunc_ttog", 32'(ttog), 32'(exp_ttog));
    chk("trunc_ttog_bit2", 32'(ttog[2]), 32'd1);
    chk("drain_seen", 32'(meas_done), 32'd1);
    chk("drain_cycles", 32'(meas_busy), 32'd4);
    chk("drain_idle", 32'(meas_idle), 32'd1);
    send(2, 4, 1);
    wait_done("bad_frame", 100);
    chk("trunc_ftog", 32'(ftog), 32'(exp_ftog));
    chk("no_extra_trunc", 32'(ttog), 32'(exp_ttog));

    // programmable inter-frame gap
    for (int g = 0; g < 2; g++) begin
      gap_cyc = 8'(gaps[g]);
      send(0, 3, 0); send(0, 3, 0);
      meas_done = 1'b0;
      wait_done("gap", 200);
      chk("gap_seen", 32'(meas_done), 32'd1);
      chk("gap_busy", 32'(meas_busy), 32'(gaps[g]));
      chk("gap_idle", 32'(meas_idle), 32'd1);
    end
    gap_cyc = '0;

    // random sink backpressure and source bubbles
    rnd_en = 1'b1;
    send(1, 5, 0); send(1, 1, 0); send(1, 7, 1); send(1, 2, 0); send(1, MAXL, 0);
    wait_done("random", 800);
    rnd_en = 1'b0;
    chk("random_ftog", 32'(ftog), 32'(exp_ftog));
    chk("random_ttog", 32'(ttog), 32'(exp_ttog));

    // strict priority: ch1 starves ch3 until ch1 goes quiet
    for (int k = 0; k < 4; k++) spq.push_back({2'd1, 8'd1});
    spq.push_back({2'd3, 8'd3});
    sp_tvalid = 4'b1010;
    for (int c = 0; c < 100; c++) begin
      @(negedge tx_clk); #3;
      if (sp_cnt >= 4) break;
    end
    chk("sp_ch1_frames", 32'(sp_cnt), 32'd4);
    @(posedge tx_clk); #1;
    sp_tvalid = 4'b1000;
    for (int c = 0; c < 100; c++) begin
      @(negedge tx_clk); #3;
      if (sp_cnt >= 5) break;
    end
    @(posedge tx_clk); #1;
    sp_tvalid = '0;
    repeat (4) @(negedge tx_clk);
    #3;
    chk("sp_all_seen", 32'(sp_cnt), 32'd5);
    chk("sp_grant_last", 32'(sp_grant), 32'd3);
    chk("sp_ftog", 32'(sp_ftog), 32'h8);
    chk("sp_ttog", 32'(sp_ttog), 32'd0);
    chk("sp_idle", 32'(sp_busy), 32'd0);

    // asynchronous reset while beat 3 of a 6-beat ch2 frame is on the bus
    n0 = nbeats;
    send(2, 6, 0);
    for (int c = 0; c < 100; c++) begin
      @(negedge tx_clk); #4;
      if (nbeats >= n0 + 3) break;
    end
    chk("rst_mid_reached", 32'(nbeats - n0), 32'd3);
    chk("rst_mid_grant_pre", 32'(grant), 32'd2);
    tx_rst = 1'b1;
    #1;
    chk("rst_mid_mvalid", 32'(m_tvalid), 32'd0);
    chk("rst_mid_sready", 32'(s_tready), 32'd0);
    chk("rst_mid_grant",  32'(grant),    32'd0);
    chk("rst_mid_busy",   32'(busy),     32'd0);
    chk("rst_mid_ftog",   32'(ftog),     32'd0);
    chk("rst_mid_ttog",   32'(ttog),     32'd0);
    for (int i = 0; i < NCH; i++) srcq[i].delete();
    expq.delete();
    exp_ftog = '0; exp_ttog = '0;
    repeat (2) @(negedge tx_clk);
    #3;
    tx_rst = 1'b0;
    send(0, 3, 0);
    wait_done("post_rst", 100);
    chk("post_rst_ftog", 32'(ftog), 32'(exp_ftog));
    chk("post_rst_ttog", 32'(ttog), 32'd0);

    repeat (2) @(negedge tx_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
